// File: rtl/slave_with_bram_split_if.sv
// Serial system-bus signals between a bus master/arbiter and the memory slave.
interface slave_with_bram_split_if;
  logic swdata;
  logic srdata;
  logic smode;
  logic mvalid;
  logic svalid;
  logic sready;
  logic ssplit;
  logic split_grant;

  modport master (
    output swdata, smode, mvalid, split_grant,
    input  srdata, svalid, sready, ssplit
  );

  modport slave (
    input  swdata, smode, mvalid, split_grant,
    output srdata, svalid, sready, ssplit
  );
endinterface

// File: rtl/slave_with_bram_split.sv
// Serial-bus memory slave: LSB-first address/data framing, internal memory,
// configurable read latency and optional split-transaction reads.
module slave_with_bram_split #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 8,
  parameter int MEM_SIZE     = 4096,
  parameter int READ_LATENCY = 2,
  parameter int SPLIT_EN     = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  slave_with_bram_split_if.slave   bus
);

  localparam int IDX_W   = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ?
                           ((ADDR_WIDTH > READ_LATENCY) ? ADDR_WIDTH : READ_LATENCY) :
                           ((DATA_WIDTH > READ_LATENCY) ? DATA_WIDTH : READ_LATENCY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Address bit 0 is taken in IDLE, so ADDR sees one bit fewer.
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_WIDTH - 2);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, MEMWR, MEMRD, SPLIT_WAIT, RDATA
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ready_en_q, ready_en_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic                   mode_q, mode_d;

  logic [DATA_WIDTH-1:0]  mem [MEM_SIZE];
  logic                   in_range;
  logic                   mem_we;
  logic [IDX_W-1:0]       idx;

  assign in_range   = ({1'b0, addr_q} < (ADDR_WIDTH + 1)'(MEM_SIZE));
  assign idx        = addr_q[IDX_W-1:0];
  assign mem_we     = (state_q == MEMWR) && in_range;
  assign ready_en_d = 1'b1;

  // State register: control only; sready stays low for one cycle after reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_en_q <= ready_en_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    shift_q <= shift_d;
    mode_q  <= mode_d;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= shift_q;
  end

  // Next-state logic; mvalid low inside a frame aborts it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (bus.mvalid && ready_en_q) state_d = ADDR;
      ADDR:       if (!bus.mvalid) state_d = IDLE;
                  else if (cnt_q == A_LAST) state_d = mode_q ? WDATA : MEMRD;
      WDATA:      if (!bus.mvalid) state_d = IDLE;
                  else if (cnt_q == D_LAST) state_d = MEMWR;
      MEMWR:      state_d = IDLE;
      MEMRD:      if (cnt_q == L_LAST) state_d = (SPLIT_EN != 0) ? SPLIT_WAIT : RDATA;
      SPLIT_WAIT: if (bus.split_grant) state_d = RDATA;
      RDATA:      if (cnt_q == D_LAST) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // The counter runs while a counting state persists and clears on every transition.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) &&
        (state_q == ADDR || state_q == WDATA || state_q == MEMRD || state_q == RDATA))
      cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    addr_d  = addr_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: if (bus.mvalid) begin
        addr_d = {bus.swdata, addr_q[ADDR_WIDTH-1:1]};
        mode_d = bus.smode;
      end
      ADDR:  if (bus.mvalid) addr_d = {bus.swdata, addr_q[ADDR_WIDTH-1:1]};
      WDATA: if (bus.mvalid) shift_d = {bus.swdata, shift_q[DATA_WIDTH-1:1]};
      MEMRD: if (cnt_q == '0) shift_d = in_range ? mem[idx] : '0;
      RDATA: shift_d = shift_q >> 1;
      default: ;
    endcase
  end

  // Outputs are forced low while reset is asserted.
  always_comb begin
    bus.sready = 1'b0;
    bus.svalid = 1'b0;
    bus.srdata = 1'b0;
    bus.ssplit = 1'b0;
    if (rstn) begin
      case (state_q)
        IDLE:              bus.sready = ready_en_q;
        MEMRD, SPLIT_WAIT: bus.ssplit = (SPLIT_EN != 0);
        RDATA: begin
          bus.svalid = 1'b1;
          bus.srdata = shift_q[0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_with_bram_split.sv
// Directed bench: a hold-the-bus instance (MEM_SIZE=2048, latency 2) and a
// split-read instance (latency 4) share one stimulus path selected by sel.
module tb_slave_with_bram_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn0, rstn1, sel, sw, sm, mv, gnt;
  logic o_valid, o_data, o_ready, o_split;
  logic saw_split, rd_valid_ok;
  logic [7:0] rd;
  int lat, w;
  int n_checks = 0;
  int n_fail   = 0;

  slave_with_bram_split_if bus0 ();
  slave_with_bram_split_if bus1 ();

  assign bus0.swdata      = sw  & ~sel;
  assign bus0.smode       = sm  & ~sel;
  assign bus0.mvalid      = mv  & ~sel;
  assign bus0.split_grant = gnt & ~sel;
  assign bus1.swdata      = sw  & sel;
  assign bus1.smode       = sm  & sel;
  assign bus1.mvalid      = mv  & sel;
  assign bus1.split_grant = gnt & sel;

  assign o_valid = sel ? bus1.svalid : bus0.svalid;
  assign o_data  = sel ? bus1.srdata : bus0.srdata;
  assign o_ready = sel ? bus1.sready : bus0.sready;
  assign o_split = sel ? bus1.ssplit : bus0.ssplit;

  slave_with_bram_split #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_SIZE(2048), .READ_LATENCY(2), .SPLIT_EN(0)
  ) dut0 (.clk(clk), .rstn(rstn0), .bus(bus0));

  slave_with_bram_split #(
    .ADDR_WIDTH(12), .DATA_WIDTH(8), .MEM_SIZE(4096), .READ_LATENCY(4), .SPLIT_EN(1)
  ) dut1 (.clk(clk), .rstn(rstn1), .bus(bus1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic mode, input logic [11:0] addr,
                            input logic [7:0] data, input int n_addr);
    saw_split = 1'b0;
    for (int i = 0; i < n_addr; i++) begin
      mv = 1'b1; sm = mode; sw = addr[i];
      tick();
      if (o_split) saw_split = 1'b1;
    end
    if (mode && n_addr == 12) begin
      for (int i = 0; i < 8; i++) begin
        mv = 1'b1; sw = data[i];
        tick();
        if (o_split) saw_split = 1'b1;
      end
    end
    mv = 1'b0; sw = 1'b0; sm = 1'b0;
  endtask

  task automatic write_word(input logic [11:0] addr, input logic [7:0] data);
    send_frame(1'b1, addr, data, 12);
    tick();
  endtask

  // Called in the first cycle after the last address bit; lat counts that cycle as 1.
  task automatic collect(output logic [7:0] d, output int l);
    l = 1;
    rd_valid_ok = 1'b1;
    d = '0;
    while (!o_valid && l < 40) begin
      if (o_split) saw_split = 1'b1;
      tick();
      l++;
    end
    for (int i = 0; i < 8; i++) begin
      if (!o_valid) rd_valid_ok = 1'b0;
      if (o_split) saw_split = 1'b1;
      d[i] = o_data;
      tick();
    end
  endtask

  task automatic read_word(input logic [11:0] addr, output logic [7:0] d, output int l);
    send_frame(1'b0, addr, 8'h00, 12);
    collect(d, l);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rstn0 = 1'b0; rstn1 = 1'b0; sel = 1'b0;
    sw = 1'b0; sm = 1'b0; mv = 1'b0; gnt = 1'b0;
    tick(); tick(); tick();

    check("rst0_sready", bus0.sready, 0);
    check("rst0_svalid", bus0.svalid, 0);
    check("rst0_srdata", bus0.srdata, 0);
    check("rst1_ssplit", bus1.ssplit, 0);
    check("rst1_sready", bus1.sready, 0);
    rstn0 = 1'b1; rstn1 = 1'b1;
    check("post_rst_sready_low", bus0.sready, 0);
    tick();
    check("post_rst_sready_high0", bus0.sready, 1);
    check("post_rst_sready_high1", bus1.sready, 1);

    // Write then read 0xA5 at 0x010 on the hold-the-bus instance
    send_frame(1'b1, 12'h010, 8'hA5, 12);
    check("memwr_sready", o_ready, 0);
    tick();
    check("after_memwr_sready", o_ready, 1);
    read_word(12'h010, rd, lat);
    check("rd010_latency", lat, 3);
    check("rd010_data", rd, 8'hA5);
    check("rd010_svalid_run", rd_valid_ok, 1);
    check("rd010_no_split", saw_split, 0);
    check("rd010_svalid_end", o_valid, 0);
    check("rd010_sready_end", o_ready, 1);

    // Out-of-range write must not alias onto 0x7FF
    write_word(12'h7FF, 8'h77);
    write_word(12'hFFF, 8'h3C);
    read_word(12'hFFF, rd, lat);
    check("rd_oor_data", rd, 8'h00);
    read_word(12'h7FF, rd, lat);
    check("rd7ff_unchanged", rd, 8'h77);

    // Aborted write frame after 5 address bits
    write_word(12'h020, 8'h5E);
    send_frame(1'b1, 12'h020, 8'hFF, 5);
    tick();
    check("abort_sready", o_ready, 1);
    read_word(12'h020, rd, lat);
    check("abort_old_value", rd, 8'h5E);

    // Reset in the first RDATA cycle (bit 0 of 0xA5 is 1)
    send_frame(1'b0, 12'h010, 8'h00, 12);
    tick(); tick();
    check("pre_rst_svalid", o_valid, 1);
    check("pre_rst_srdata", o_data, 1);
    rstn0 = 1'b0;
    tick();
    rstn0 = 1'b1;
    check("midrst_svalid", o_valid, 0);
    check("midrst_srdata", o_data, 0);
    check("midrst_sready", o_ready, 0);
    tick();
    check("midrst_sready_next", o_ready, 1);
    read_word(12'h010, rd, lat);
    check("midrst_mem_kept", rd, 8'hA5);

    // Back-to-back writes, second one issued on the first sready cycle
    send_frame(1'b1, 12'h002, 8'h11, 12);
    w = 0;
    while (!o_ready && w < 10) begin tick(); w++; end
    check("b2b_sready_wait", w, 1);
    send_frame(1'b1, 12'h003, 8'h22, 12);
    tick();
    read_word(12'h002, rd, lat);
    check("b2b_rd002", rd, 8'h11);
    read_word(12'h003, rd, lat);
    check("b2b_rd003", rd, 8'h22);

    // Split read on the latency-4 instance
    sel = 1'b1;
    write_word(12'h001, 8'h5A);
    check("split_write_no_ssplit", saw_split, 0);
    send_frame(1'b0, 12'h001, 8'h00, 12);
    check("split_memrd_ssplit", o_split, 1);
    check("split_memrd_sready", o_ready, 0);
    tick();
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("early_grant_svalid", o_valid, 0);
    check("early_grant_ssplit", o_split, 1);
    tick(); tick();
    check("splitwait_svalid_a", o_valid, 0);
    tick();
    check("splitwait_svalid_b", o_valid, 0);
    check("splitwait_ssplit", o_split, 1);
    check("splitwait_sready", o_ready, 0);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    check("granted_svalid", o_valid, 1);
    check("granted_ssplit", o_split, 0);
    collect(rd, lat);
    check("split_rd_data", rd, 8'h5A);
    check("split_rd_svalid_run", rd_valid_ok, 1);
    check("split_rd_sready_end", o_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
